// File: rtl/register_file.sv
// Architectural register file: DEPTH x WIDTH storage, two read ports, one write port, per-register busy scoreboard.
// Latency: reads are combinational (0 cycles); writes and busy updates land on the next rising clk edge.
// Backpressure: none; every write and issue is accepted in the cycle it is presented.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             issue,
    input  logic [AW-1:0]    issue_rd
);

    // Register contents and the RAW-hazard scoreboard; nothing else is stored.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // One-hot write / issue selects; an out-of-range or hard-wired-zero target selects nothing.
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] iss_sel;

    // Entry 0 has no storage behaviour when it is the hard-wired zero register.
    function automatic logic entry_live(input int idx);
        return !(ZERO_REG != 0 && idx == 0);
    endfunction

    // A read address outside the array, or the zero register, returns 0 and not-busy.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // Decode the write and issue addresses into per-entry strobes.
    always_comb begin
        wr_sel  = '0;
        iss_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live(i)) begin
                wr_sel[i]  = we    && (rd_addr  == AW'(i));
                iss_sel[i] = issue && (issue_rd == AW'(i));
            end
        end
    end

    // Data array: synchronous clear, otherwise load the selected entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= rd_data;
                end
            end
        end
    end

    // Scoreboard: writeback retires the producer, but a same-cycle issue is newer and wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_sel) | iss_sel;
        end
    end

    // Read port 1: invalid address -> 0, live forward from the write port, else the array.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (addr_valid(rs1_addr)) begin
            if (BYPASS != 0 && reset && we && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rs1_addr == AW'(i)) begin
                        rs1_data = mem[i];
                        rs1_busy = busy[i];
                    end
                end
            end
        end
    end

    // Read port 2: identical selection rules, independent address.
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (addr_valid(rs2_addr)) begin
            if (BYPASS != 0 && reset && we && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rs2_addr == AW'(i)) begin
                        rs2_data = mem[i];
                        rs2_busy = busy[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three instances (default, no-bypass, 8x12 without zero register)
// checked each step against an array-based reference model.
// Directed steps first, then a randomized phase with occasional resets.
module tb_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Stimulus shared by the two 32x32 instances.
    logic [4:0]  a_rs1, a_rs2, a_rd, a_ird;
    logic        a_we, a_iss;
    logic [31:0] a_rdd;
    // Stimulus for the 8-bit, 12-entry instance.
    logic [3:0]  b_rs1, b_rs2, b_rd, b_ird;
    logic        b_we, b_iss;
    logic [7:0]  b_rdd;

    logic [31:0] d0_rs1d, d0_rs2d, d1_rs1d, d1_rs2d;
    logic        d0_rs1b, d0_rs2b, d1_rs1b, d1_rs2b;
    logic [7:0]  d2_rs1d, d2_rs2d;
    logic        d2_rs1b, d2_rs2b;

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .reset(rst_n),
        .rs1_addr(a_rs1), .rs2_addr(a_rs2),
        .rs1_data(d0_rs1d), .rs2_data(d0_rs2d),
        .rs1_busy(d0_rs1b), .rs2_busy(d0_rs2b),
        .we(a_we), .rd_addr(a_rd), .rd_data(a_rdd),
        .issue(a_iss), .issue_rd(a_ird)
    );

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(rst_n),
        .rs1_addr(a_rs1), .rs2_addr(a_rs2),
        .rs1_data(d1_rs1d), .rs2_data(d1_rs2d),
        .rs1_busy(d1_rs1b), .rs2_busy(d1_rs2b),
        .we(a_we), .rd_addr(a_rd), .rd_data(a_rdd),
        .issue(a_iss), .issue_rd(a_ird)
    );

    register_file #(.WIDTH(8), .DEPTH(12), .ZERO_REG(0), .BYPASS(1)) dut2 (
        .clk(clk), .reset(rst_n),
        .rs1_addr(b_rs1), .rs2_addr(b_rs2),
        .rs1_data(d2_rs1d), .rs2_data(d2_rs2d),
        .rs1_busy(d2_rs1b), .rs2_busy(d2_rs2b),
        .we(b_we), .rd_addr(b_rd), .rd_data(b_rdd),
        .issue(b_iss), .issue_rd(b_ird)
    );

    // Reference model: plain arrays indexed by instance, with each instance's configuration.
    logic [31:0] md [3][256];
    bit          mb [3][256];
    int          m_depth [3] = '{32, 32, 12};
    bit          m_zero  [3] = '{1'b1, 1'b1, 1'b0};
    bit          m_byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    int checks = 0;
    int errors = 0;

    function automatic bit mvalid(input int i, input int a);
        return (a < m_depth[i]) && !(m_zero[i] && a == 0);
    endfunction

    function automatic logic [31:0] mdata(input int i, input int a, input bit w,
                                          input int rd, input logic [31:0] d);
        if (!mvalid(i, a)) return 32'h0;
        if (m_byp[i] && w && rd == a && rst_n) return d & m_mask[i];
        return md[i][a];
    endfunction

    function automatic bit mbusy(input int i, input int a, input bit w, input int rd);
        if (!mvalid(i, a)) return 1'b0;
        if (m_byp[i] && w && rd == a && rst_n) return 1'b0;
        return mb[i][a];
    endfunction

    task automatic medge(input int i, input bit w, input int rd, input logic [31:0] d,
                         input bit is, input int ird);
        if (!rst_n) begin
            for (int k = 0; k < 256; k++) begin
                md[i][k] = 32'h0;
                mb[i][k] = 1'b0;
            end
        end else begin
            if (w && mvalid(i, rd)) begin
                md[i][rd] = d & m_mask[i];
                mb[i][rd] = 1'b0;
            end
            if (is && mvalid(i, ird)) mb[i][ird] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, apply it to the model, then leave 1 time unit for new drives.
    task automatic cyc();
        @(posedge clk);
        medge(0, a_we, a_rd, a_rdd, a_iss, a_ird);
        medge(1, a_we, a_rd, a_rdd, a_iss, a_ird);
        medge(2, b_we, b_rd, {24'h0, b_rdd}, b_iss, b_ird);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_iss = 1'b0;
        b_we = 1'b0; b_iss = 1'b0;
    endtask

    // Compare every read output of every instance against the model.
    task automatic check_all(input string tag);
        #1;
        chk({tag, " d0.rs1_data"}, d0_rs1d, mdata(0, a_rs1, a_we, a_rd, a_rdd));
        chk({tag, " d0.rs2_data"}, d0_rs2d, mdata(0, a_rs2, a_we, a_rd, a_rdd));
        chk({tag, " d0.rs1_busy"}, 32'(d0_rs1b), 32'(mbusy(0, a_rs1, a_we, a_rd)));
        chk({tag, " d0.rs2_busy"}, 32'(d0_rs2b), 32'(mbusy(0, a_rs2, a_we, a_rd)));
        chk({tag, " d1.rs1_data"}, d1_rs1d, mdata(1, a_rs1, a_we, a_rd, a_rdd));
        chk({tag, " d1.rs2_data"}, d1_rs2d, mdata(1, a_rs2, a_we, a_rd, a_rdd));
        chk({tag, " d1.rs1_busy"}, 32'(d1_rs1b), 32'(mbusy(1, a_rs1, a_we, a_rd)));
        chk({tag, " d1.rs2_busy"}, 32'(d1_rs2b), 32'(mbusy(1, a_rs2, a_we, a_rd)));
        chk({tag, " d2.rs1_data"}, {24'h0, d2_rs1d}, mdata(2, b_rs1, b_we, b_rd, {24'h0, b_rdd}));
        chk({tag, " d2.rs2_data"}, {24'h0, d2_rs2d}, mdata(2, b_rs2, b_we, b_rd, {24'h0, b_rdd}));
        chk({tag, " d2.rs1_busy"}, 32'(d2_rs1b), 32'(mbusy(2, b_rs1, b_we, b_rd)));
        chk({tag, " d2.rs2_busy"}, 32'(d2_rs2b), 32'(mbusy(2, b_rs2, b_we, b_rd)));
    endtask

    initial begin
        rst_n = 1'b1;
        a_rs1 = '0; a_rs2 = '0; a_rd = '0; a_ird = '0; a_rdd = '0;
        b_rs1 = '0; b_rs2 = '0; b_rd = '0; b_ird = '0; b_rdd = '0;
        idle();
        #2;

        // Reset edge with a write and an issue pending: both must be lost.
        rst_n = 1'b0;
        a_we = 1'b1; a_rd = 5'd5; a_rdd = 32'h1111_1111; a_iss = 1'b1; a_ird = 5'd6;
        b_we = 1'b1; b_rd = 4'd5; b_rdd = 8'h11;        b_iss = 1'b1; b_ird = 4'd6;
        cyc();
        rst_n = 1'b1;
        idle();

        // Sweep all addresses after reset.
        for (int a = 0; a < 32; a++) begin
            a_rs1 = 5'(a); a_rs2 = 5'(31 - a);
            b_rs1 = 4'(a % 16); b_rs2 = 4'(15 - (a % 16));
            check_all("rst_sweep");
            chk("rst_sweep const", d0_rs1d | d1_rs2d | {24'h0, d2_rs1d}, 32'h0);
            cyc();
        end

        // Write and read back.
        a_we = 1'b1; a_rd = 5'd5;  a_rdd = 32'hDEAD_BEEF; cyc();
        a_rd = 5'd31; a_rdd = 32'h1234_5678;              cyc();
        idle();
        a_rs1 = 5'd5; a_rs2 = 5'd31;
        check_all("readback");
        chk("readback r5", d0_rs1d, 32'hDEAD_BEEF);
        chk("readback r31", d0_rs2d, 32'h1234_5678);

        // The zero register ignores writes, including through the bypass.
        a_we = 1'b1; a_rd = 5'd0; a_rdd = 32'hFFFF_FFFF; a_rs1 = 5'd0;
        check_all("r0 write pending");
        cyc();
        idle();
        check_all("r0 write");
        chk("r0 reads zero", d0_rs1d, 32'h0);

        // Same-cycle forwarding versus the no-bypass instance.
        a_rs1 = 5'd7; a_rs2 = 5'd7;
        a_we = 1'b1; a_rd = 5'd7; a_rdd = 32'hA5A5_A5A5;
        b_rs1 = 4'd7; b_rs2 = 4'd7;
        b_we = 1'b1; b_rd = 4'd7; b_rdd = 8'hA5;
        check_all("bypass");
        chk("bypass d0", d0_rs2d, 32'hA5A5_A5A5);
        chk("no bypass d1", d1_rs1d, 32'h0);
        cyc();
        idle();
        check_all("bypass after");
        chk("d1 after edge", d1_rs1d, 32'hA5A5_A5A5);

        // Scoreboard set, clear, and issue-beats-write.
        a_iss = 1'b1; a_ird = 5'd3; cyc(); idle();
        a_rs1 = 5'd3; a_rs2 = 5'd3;
        check_all("issue r3");
        chk("r3 busy", 32'(d0_rs1b), 32'd1);
        a_we = 1'b1; a_rd = 5'd3; a_rdd = 32'h42; cyc(); idle();
        check_all("write r3");
        chk("r3 not busy", 32'(d1_rs1b), 32'd0);
        a_we = 1'b1; a_rd = 5'd3; a_rdd = 32'h99;
        a_iss = 1'b1; a_ird = 5'd3;
        check_all("issue+write r3 pending");
        cyc(); idle();
        check_all("issue+write r3");
        chk("r3 busy again", 32'(d0_rs2b), 32'd1);
        chk("r3 data", d1_rs2d, 32'h99);

        // Reset in the middle of traffic.
        a_we = 1'b1; a_rd = 5'd9; a_rdd = 32'h55; cyc(); idle();
        a_iss = 1'b1; a_ird = 5'd9; cyc(); idle();
        a_rs1 = 5'd9;
        check_all("r9 busy");
        rst_n = 1'b0;
        a_we = 1'b1; a_rd = 5'd9; a_rdd = 32'h77;
        check_all("reset pending");
        cyc();
        rst_n = 1'b1; idle();
        check_all("after mid reset");
        chk("r9 cleared", d0_rs1d, 32'h0);

        // Small instance: r0 is ordinary, addresses >= 12 are dead.
        b_we = 1'b1; b_rd = 4'd0; b_rdd = 8'h7F; cyc(); idle();
        b_rs1 = 4'd0;
        check_all("small r0");
        chk("small r0 7F", {24'h0, d2_rs1d}, 32'h7F);
        b_we = 1'b1; b_rd = 4'd13; b_rdd = 8'h11;
        b_iss = 1'b1; b_ird = 4'd13;
        b_rs1 = 4'd13; b_rs2 = 4'd11;
        check_all("small addr13 pending");
        cyc(); idle();
        check_all("small addr13");
        chk("small addr13 data", {24'h0, d2_rs1d}, 32'h0);

        // Randomized traffic with rare resets.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 47) != 0);
            a_we  = 1'($urandom_range(0, 1)); a_iss = 1'($urandom_range(0, 1));
            a_rd  = 5'($urandom_range(0, 31)); a_ird = 5'($urandom_range(0, 31));
            a_rdd = $urandom();
            a_rs1 = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
            a_rs2 = ($urandom_range(0, 3) == 0) ? a_rs1 : 5'($urandom_range(0, 31));
            b_we  = 1'($urandom_range(0, 1)); b_iss = 1'($urandom_range(0, 1));
            b_rd  = 4'($urandom_range(0, 15)); b_ird = 4'($urandom_range(0, 15));
            b_rdd = 8'($urandom());
            b_rs1 = ($urandom_range(0, 3) == 0) ? b_rd : 4'($urandom_range(0, 15));
            b_rs2 = 4'($urandom_range(0, 15));
            check_all("random");
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
